// File: rtl/ram_bridge_pkg.sv
// Shared types and defaults for the single-port RAM bus bridge.
// Holds the bridge state encoding, default parameter values and the
// address-width helper used by the interface and the top level.
package ram_bridge_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bridge_state_e;

  localparam int DEF_WORD_COUNT = 2048;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MASK_W     = 1;
  localparam int DEF_RSP_DEPTH  = 2;

  // Exact address width for a RAM of 'words' entries, never narrower than 1 bit.
  function automatic int addr_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ram_1wrs_bus_bridge_if.sv
// Command/response bus between the CPU-side interconnect and the RAM bridge.
// master = interconnect side (issues commands, consumes responses),
// slave  = bridge side.
interface ram_1wrs_bus_bridge_if #(
  parameter int ADDR_W = ram_bridge_pkg::addr_w(ram_bridge_pkg::DEF_WORD_COUNT),
  parameter int DATA_W = ram_bridge_pkg::DEF_DATA_W,
  parameter int MASK_W = ram_bridge_pkg::DEF_MASK_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [MASK_W-1:0] cmd_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_mask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_mask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_bridge_rsp_fifo.sv
// Synchronous response FIFO, DATA_W x DEPTH, with an occupancy count.
// A push while full is accepted when a pop happens in the same cycle.
module ram_bridge_rsp_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  // Qualify push/pop and compute next pointers and count; pointers wrap at DEPTH.
  always_comb begin
    pop_ok   = pop_i & (count_q != '0);
    push_ok  = push_i & ((count_q != CNT_W'(DEPTH)) | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; data is not reset since occupancy gates its use.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_1wrs_bus_bridge.sv
// Bus bridge driving a single-port 1-write/read-shared RAM.
// Commands arrive on a valid/ready bus; reads return 2 cycles after accept
// through a small response FIFO. Read credit (buffered + in flight) is
// limited to RSP_DEPTH, so a response always has room when it arrives.
// Build option: define RAM_CLEAR_EN to zero-fill the RAM after every reset
// before commands are accepted; otherwise the bridge runs straight out of reset.
module ram_1wrs_bus_bridge
  import ram_bridge_pkg::*;
#(
  parameter  int WORD_COUNT = DEF_WORD_COUNT,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int MASK_W     = DEF_MASK_W,
  parameter  int RSP_DEPTH  = DEF_RSP_DEPTH,
  localparam int ADDR_W     = addr_w(WORD_COUNT),
  localparam int CNT_W      = $clog2(RSP_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  ram_1wrs_bus_bridge_if.slave bus,
  output logic                init_done,
  output logic                ram_en,
  output logic                ram_wr,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wrData,
  output logic [MASK_W-1:0]   ram_mask,
  input  logic [DATA_W-1:0]   ram_rdData
);

  bridge_state_e    state_q;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic             run;
  logic             credit;
  logic             cmd_ready;
  logic             cmd_fire;

`ifdef RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q;

  // Zero-fill sequencer: walk every address once, then hand over to RUN.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == ADDR_W'(WORD_COUNT - 1)) begin
        state_q <= ST_RUN;
      end
    end
  end
`else
  // Without zero-fill the bridge is in RUN from the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_q;
    end
  end
`endif

  // Credit counts the in-flight read as well, so rsp_ready never reaches cmd_ready.
  assign run        = resetn & (state_q == ST_RUN);
  assign credit     = (32'(fifo_count) + 32'(inflight_q)) < RSP_DEPTH;
  assign cmd_ready  = run & (bus.cmd_write | credit);
  assign cmd_fire   = bus.cmd_valid & cmd_ready;
  assign inflight_d = cmd_fire & ~bus.cmd_write;

  assign bus.cmd_ready = cmd_ready;
  assign init_done     = run;

  // A read accepted this cycle has its RAM data arriving next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // RAM port mux: zero-fill writes while clearing, otherwise pass the accepted command.
  always_comb begin
    ram_en     = cmd_fire;
    ram_wr     = cmd_fire & bus.cmd_write;
    ram_addr   = bus.cmd_addr;
    ram_wrData = bus.cmd_data;
    ram_mask   = bus.cmd_mask;
`ifdef RAM_CLEAR_EN
    if (resetn && (state_q == ST_CLEAR)) begin
      ram_en     = 1'b1;
      ram_wr     = 1'b1;
      ram_addr   = clr_cnt_q;
      ram_wrData = '0;
      ram_mask   = '1;
    end
`endif
  end

  ram_bridge_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (inflight_q),
    .push_data_i (ram_rdData),
    .pop_i       (bus.rsp_ready),
    .valid_o     (bus.rsp_valid),
    .data_o      (bus.rsp_data),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_ram_1wrs_bus_bridge.sv
// Directed bench for ram_1wrs_bus_bridge with a 16-word RAM model.
// Works with or without RAM_CLEAR_EN defined.
module tb_ram_1wrs_bus_bridge;

  localparam int WC = 16;
  localparam int DW = 32;
  localparam int MW = 1;
  localparam int RD = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          init_done;
  logic          ram_en;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wrData;
  logic [MW-1:0] ram_mask;
  logic [DW-1:0] ram_rdData = '0;

  logic [DW-1:0] mem [WC] = '{default: 32'hBAD0_BAD0};
  logic [DW-1:0] sh  [WC];
  logic [DW-1:0] expq [$];
  logic [DW-1:0] gotq [$];

  int asserts = 0;
  int fails   = 0;

  ram_1wrs_bus_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  ram_1wrs_bus_bridge #(
    .WORD_COUNT (WC),
    .DATA_W     (DW),
    .MASK_W     (MW),
    .RSP_DEPTH  (RD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .init_done  (init_done),
    .ram_en     (ram_en),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_wrData (ram_wrData),
    .ram_mask   (ram_mask),
    .ram_rdData (ram_rdData)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, data valid one cycle after a read.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        if (ram_mask[0]) mem[ram_addr] <= ram_wrData;
      end else begin
        ram_rdData <= mem[ram_addr];
      end
    end
  end

  // Response monitor: records every consumed response.
  always @(negedge clk) begin
    if (resetn && bus.rsp_valid && bus.rsp_ready) gotq.push_back(bus.rsp_data);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Present one command until accepted; records expected read data from the shadow memory.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit rnd, output int ncyc);
    bit done = 0;
    ncyc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_mask  = 1'b1;
    while (!done && ncyc < 40) begin
      if (rnd) bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.cmd_ready) begin
        done = 1;
        if (w) sh[a] = d;
        else   expq.push_back(sh[a]);
      end
      @(posedge clk); #1;
      ncyc++;
    end
    bus.cmd_valid = 1'b0;
    if (!done) begin
      asserts++; fails++;
      $display("[TB] FAIL issue_timeout addr %0d write %0b not accepted in 40 cycles", a, w);
    end
  endtask

  // Let outstanding responses return, then idle a few cycles to expose duplicates.
  task automatic wait_drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (gotq.size() < expq.size() && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    int n;
    bit seq_ok;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0;
    bus.cmd_data = '0; bus.cmd_mask = 1'b1; bus.rsp_ready = 0;
    resetn = 1'b0;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    asserts++; if (init_done !== 1'b0) begin fails++; $display("[TB] FAIL rst_init_done got %b expected 0", init_done); end
    asserts++; if (bus.cmd_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_cmd_ready got %b expected 0", bus.cmd_ready); end
    asserts++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_rsp_valid got %b expected 0", bus.rsp_valid); end
    asserts++; if (ram_en !== 1'b0) begin fails++; $display("[TB] FAIL rst_ram_en got %b expected 0", ram_en); end
    asserts++; if (ram_wr !== 1'b0) begin fails++; $display("[TB] FAIL rst_ram_wr got %b expected 0", ram_wr); end
    @(posedge clk); #1;
    resetn = 1'b1;
`ifdef RAM_CLEAR_EN
    n = 0; seq_ok = 1;
    while (n < 64) begin
      @(negedge clk);
      if (init_done) break;
      if (!(ram_en && ram_wr && ram_addr == n[AW-1:0] && ram_wrData == '0 && !bus.cmd_ready)) seq_ok = 0;
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    asserts++; if (n != 16) begin fails++; $display("[TB] FAIL clear_cycles got %0d expected 16", n); end
    asserts++; if (!seq_ok) begin fails++; $display("[TB] FAIL clear_sequence got bad step expected addr 0..15 zero writes"); end
    foreach (sh[i]) sh[i] = '0;
`else
    seq_ok = 1; n = 0;
    @(negedge clk);
    asserts++; if (init_done !== 1'b1) begin fails++; $display("[TB] FAIL first_init_done got %b expected 1", init_done); end
    asserts++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL first_cmd_ready got %b expected 1", bus.cmd_ready); end
    @(posedge clk); #1;
`endif
  endtask

`ifdef RAM_CLEAR_EN
  task automatic test_read_all_zero();
    int n;
    bus.rsp_ready = 1'b1;
    for (int a = 0; a < WC; a++) issue(1'b0, a[AW-1:0], '0, 0, n);
    wait_drain();
    asserts++; if (gotq.size() != WC) begin fails++; $display("[TB] FAIL zero_count got %0d expected %0d", gotq.size(), WC); end
    foreach (gotq[i]) begin
      asserts++;
      if (gotq[i] !== 32'h0) begin fails++; $display("[TB] FAIL zero_data[%0d] got %h expected 00000000", i, gotq[i]); end
    end
    expq.delete(); gotq.delete();
  endtask
`else
  task automatic test_no_clear();
    int n;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 4'd0, 32'h1234_5678, 0, n);
    issue(1'b0, 4'd0, '0, 0, n);
    wait_drain();
    asserts++; if (gotq.size() != 1) begin fails++; $display("[TB] FAIL noclr_count got %0d expected 1", gotq.size()); end
    if (gotq.size() > 0) begin
      asserts++;
      if (gotq[0] !== 32'h1234_5678) begin fails++; $display("[TB] FAIL noclr_data got %h expected 12345678", gotq[0]); end
    end
    expq.delete(); gotq.delete();
  endtask
`endif

  task automatic test_raw_latency();
    int n;
    bus.rsp_ready = 1'b1;
    issue(1'b1, 4'd5, 32'hDEAD_BEEF, 0, n);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'd5;
    @(negedge clk);
    asserts++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL raw_read_ready got %b expected 1", bus.cmd_ready); end
    asserts++; if ({ram_en, ram_wr} !== 2'b10) begin fails++; $display("[TB] FAIL raw_ram_strobe got %b expected 10", {ram_en, ram_wr}); end
    if (bus.cmd_ready) expq.push_back(sh[5]);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    asserts++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL raw_valid_t1 got %b expected 0", bus.rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    asserts++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL raw_valid_t2 got %b expected 1", bus.rsp_valid); end
    asserts++; if (bus.rsp_data !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL raw_data got %h expected deadbeef", bus.rsp_data); end
    @(posedge clk); #1;
    wait_drain();
    asserts++; if (gotq.size() != 1) begin fails++; $display("[TB] FAIL raw_count got %0d expected 1", gotq.size()); end
    expq.delete(); gotq.delete();
  endtask

  task automatic test_credit();
    int n;
    bit stalled = 1;
    bus.rsp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) issue(1'b1, i[AW-1:0], 32'h1111_0000 + i, 0, n);
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'd1, '0, 0, n);
    issue(1'b0, 4'd2, '0, 0, n);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.cmd_ready !== 1'b0) stalled = 0;
      if (c == 1) begin
        asserts++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1111_0001) begin
          fails++; $display("[TB] FAIL credit_hold_a got %b/%h expected 1/11110001", bus.rsp_valid, bus.rsp_data);
        end
      end
      if (c == 3) begin
        asserts++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1111_0001) begin
          fails++; $display("[TB] FAIL credit_hold_b got %b/%h expected 1/11110001", bus.rsp_valid, bus.rsp_data);
        end
      end
      @(posedge clk); #1;
    end
    asserts++; if (!stalled) begin fails++; $display("[TB] FAIL credit_stall got ready expected cmd_ready 0 with 2 reads held"); end
    bus.rsp_ready = 1'b1;
    issue(1'b0, 4'd3, '0, 0, n);
    issue(1'b0, 4'd4, '0, 0, n);
    wait_drain();
    asserts++; if (gotq.size() != 4) begin fails++; $display("[TB] FAIL credit_count got %0d expected 4", gotq.size()); end
    for (int i = 0; i < 4 && i < gotq.size(); i++) begin
      asserts++;
      if (gotq[i] !== 32'h1111_0001 + i) begin
        fails++; $display("[TB] FAIL credit_order[%0d] got %h expected %h", i, gotq[i], 32'h1111_0001 + i);
      end
    end
    expq.delete(); gotq.delete();
  endtask

  task automatic test_random();
    int n;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < WC; i++) issue(1'b1, i[AW-1:0], 32'hC0DE_0000 + i, 0, n);
    for (int k = 0; k < 200; k++) begin
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, WC - 1));
      d = $urandom;
      issue(w, a, d, 1, n);
    end
    wait_drain();
    asserts++; if (gotq.size() != expq.size()) begin fails++; $display("[TB] FAIL rand_count got %0d expected %0d", gotq.size(), expq.size()); end
    foreach (expq[i]) begin
      if (i < gotq.size()) begin
        asserts++;
        if (gotq[i] !== expq[i]) begin fails++; $display("[TB] FAIL rand_data[%0d] got %h expected %h", i, gotq[i], expq[i]); end
      end
    end
    expq.delete(); gotq.delete();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int acc_n = 0;
    int acc_cyc [6];
    bus.rsp_ready = 1'b1;
    while (acc_n < 6 && n < 30) begin
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'(6 + acc_n);
      @(negedge clk);
      if (bus.cmd_ready) begin
        expq.push_back(sh[bus.cmd_addr]);
        acc_cyc[acc_n] = n;
        acc_n++;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    asserts++; if (n != 8) begin fails++; $display("[TB] FAIL b2b_cycles got %0d expected 8", n); end
    asserts++; if (acc_cyc[1] != 1) begin fails++; $display("[TB] FAIL b2b_second got cycle %0d expected 1", acc_cyc[1]); end
    asserts++; if (acc_cyc[2] != 3) begin fails++; $display("[TB] FAIL b2b_third got cycle %0d expected 3", acc_cyc[2]); end
    wait_drain();
    asserts++; if (gotq.size() != 6) begin fails++; $display("[TB] FAIL b2b_count got %0d expected 6", gotq.size()); end
    foreach (expq[i]) begin
      if (i < gotq.size()) begin
        asserts++;
        if (gotq[i] !== expq[i]) begin fails++; $display("[TB] FAIL b2b_data[%0d] got %h expected %h", i, gotq[i], expq[i]); end
      end
    end
    expq.delete(); gotq.delete();
  endtask

  task automatic test_reset_flush();
    int n;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'd1, '0, 0, n);
    issue(1'b0, 4'd2, '0, 0, n);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    asserts++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL flush_pre_valid got %b expected 1", bus.rsp_valid); end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    asserts++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_rsp_valid got %b expected 0", bus.rsp_valid); end
    expq.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
`ifdef RAM_CLEAR_EN
    asserts++;
    if (!(ram_en && ram_wr && ram_addr == 4'd0)) begin
      fails++; $display("[TB] FAIL flush_clear_start got en %b wr %b addr %0d expected 1 1 0", ram_en, ram_wr, ram_addr);
    end
    n = 0;
    while (!init_done && n < 64) begin
      @(posedge clk); #1; @(negedge clk);
      n++;
    end
    asserts++; if (n != 16) begin fails++; $display("[TB] FAIL flush_clear_cycles got %0d expected 16", n); end
    foreach (sh[i]) sh[i] = '0;
`else
    asserts++; if (bus.cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_cmd_ready got %b expected 1", bus.cmd_ready); end
`endif
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    issue(1'b0, 4'd1, '0, 0, n);
    wait_drain();
    asserts++; if (gotq.size() != 1) begin fails++; $display("[TB] FAIL flush_count got %0d expected 1", gotq.size()); end
    if (gotq.size() > 0 && expq.size() > 0) begin
      asserts++;
      if (gotq[0] !== expq[0]) begin fails++; $display("[TB] FAIL flush_data got %h expected %h", gotq[0], expq[0]); end
    end
    expq.delete(); gotq.delete();
  endtask

  initial begin
    $display("[TB] starting ram_1wrs_bus_bridge bench");
    test_reset();
`ifdef RAM_CLEAR_EN
    test_read_all_zero();
`else
    test_no_clear();
`endif
    test_raw_latency();
    test_credit();
    test_random();
    test_back_to_back();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
